// File: rtl/gpio_responder_if.sv
// Processor data-bus view of the GPIO slave: word address, select,
// write strobe, write data and combinational read data.
interface gpio_responder_if #(
    parameter int DW = 32
);
    logic [2:0]    addr;
    logic          sel;
    logic          we;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;

    modport master (output addr, sel, we, wd, input rd);
    modport slave  (input addr, sel, we, wd, output rd);
endinterface

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO: synchronized inputs, R/W outputs, sticky W1C
// change flags with per-port enables driving a registered level irq.
module gpio_responder #(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    gpio_responder_if.slave bus,
    input  logic [DW-1:0] gpi1,
    input  logic [DW-1:0] gpi2,
    output logic [DW-1:0] gpo1,
    output logic [DW-1:0] gpo2,
    output logic          irq
);
    localparam int WMAX = SYNC_STAGES + 1;

    logic [DW-1:0] r_s1 [SYNC_STAGES];
    logic [DW-1:0] r_s2 [SYNC_STAGES];
    logic [DW-1:0] r_h1;
    logic [DW-1:0] r_h2;
    logic [DW-1:0] r_gpo1;
    logic [DW-1:0] r_gpo2;
    logic [1:0]    r_chg;
    logic [1:0]    r_ien;
    logic [2:0]    r_warm;
    logic          r_irq;

    logic [DW-1:0] w_g1;
    logic [DW-1:0] w_g2;
    logic [DW-1:0] w_rd;
    logic          w_wr;
    logic          w_warm;
    logic [1:0]    w_set;
    logic [1:0]    w_clr;
    logic [1:0]    w_chg;

    assign w_g1   = r_s1[SYNC_STAGES-1];
    assign w_g2   = r_s2[SYNC_STAGES-1];
    assign w_wr   = bus.sel & bus.we;
    assign w_warm = (r_warm == 3'(WMAX));

    // Flags stay quiet until the chain and history hold post-reset data
    assign w_set = w_warm ? {w_g2 != r_h2, w_g1 != r_h1} : 2'b00;
    assign w_clr = (w_wr && bus.addr == 3'd4) ? bus.wd[1:0] : 2'b00;
    assign w_chg = (r_chg & ~w_clr) | w_set;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_s1[i] <= '0;
                r_s2[i] <= '0;
            end
            r_h1   <= '0;
            r_h2   <= '0;
            r_gpo1 <= '0;
            r_gpo2 <= '0;
            r_chg  <= '0;
            r_ien  <= '0;
            r_warm <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_s1[0] <= gpi1;
            r_s2[0] <= gpi2;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_s1[i] <= r_s1[i-1];
                r_s2[i] <= r_s2[i-1];
            end
            r_h1   <= w_g1;
            r_h2   <= w_g2;
            r_warm <= w_warm ? r_warm : r_warm + 3'd1;
            r_chg  <= w_chg;
            r_irq  <= |(r_chg & r_ien);
            if (w_wr) begin
                case (bus.addr)
                    3'd2:    r_gpo1 <= bus.wd;
                    3'd3:    r_gpo2 <= bus.wd;
                    3'd5:    r_ien  <= bus.wd[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (bus.sel) begin
            case (bus.addr)
                3'd0:    w_rd = w_g1;
                3'd1:    w_rd = w_g2;
                3'd2:    w_rd = r_gpo1;
                3'd3:    w_rd = r_gpo2;
                3'd4:    w_rd = {{(DW-2){1'b0}}, r_chg};
                3'd5:    w_rd = {{(DW-2){1'b0}}, r_ien};
                default: w_rd = '0;
            endcase
        end
    end

    assign bus.rd = w_rd;
    assign gpo1   = r_gpo1;
    assign gpo2   = r_gpo2;
    assign irq    = r_irq;
endmodule

// File: tb/tb_gpio_responder.sv
// Directed and randomized checks of gpio_responder against a
// history-based model of input timing, flags, enables and outputs.
module tb_gpio_responder;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] gpi1 = '0;
    logic [31:0] gpi2 = '0;
    logic [31:0] gpo1;
    logic [31:0] gpo2;
    logic        irq;

    gpio_responder_if #(.DW(32)) bus ();

    gpio_responder #(.DW(32), .SYNC_STAGES(2)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .bus  (bus.slave),
        .gpi1 (gpi1),
        .gpi2 (gpi2),
        .gpo1 (gpo1),
        .gpo2 (gpo2),
        .irq  (irq)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: g1[k]/g2[k] = input value present before edge k since reset
    int          n;
    logic [31:0] g1 [0:4095];
    logic [31:0] g2 [0:4095];
    logic [31:0] m_gpi1, m_gpi2, m_gpo1, m_gpo2;
    logic [1:0]  m_chg, m_ien;
    logic        m_irq;

    function automatic logic [31:0] gv1(int k);
        return (k < 1) ? 32'd0 : g1[k];
    endfunction

    function automatic logic [31:0] gv2(int k);
        return (k < 1) ? 32'd0 : g2[k];
    endfunction

    function automatic logic [31:0] m_rd(logic [2:0] a);
        case (a)
            3'd0:    return m_gpi1;
            3'd1:    return m_gpi2;
            3'd2:    return m_gpo1;
            3'd3:    return m_gpo2;
            3'd4:    return {30'd0, m_chg};
            3'd5:    return {30'd0, m_ien};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        n = 0;
        m_gpi1 = '0; m_gpi2 = '0;
        m_gpo1 = '0; m_gpo2 = '0;
        m_chg = '0; m_ien = '0; m_irq = 1'b0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       wen;
        logic [2:0] a;
        logic [31:0] d;
        logic [1:0] set, clr;
        wen = bus.sel && bus.we;
        a = bus.addr;
        d = bus.wd;
        n++;
        g1[n] = gpi1;
        g2[n] = gpi2;
        m_irq = |(m_chg & m_ien);
        set = 2'b00;
        // Readable value of edge n-1 vs one edge older, after warm-up
        if (n >= 4) begin
            set[0] = (gv1(n-2) != gv1(n-3));
            set[1] = (gv2(n-2) != gv2(n-3));
        end
        clr = (wen && a == 3'd4) ? d[1:0] : 2'b00;
        m_chg = (m_chg & ~clr) | set;
        if (wen && a == 3'd2) m_gpo1 = d;
        if (wen && a == 3'd3) m_gpo2 = d;
        if (wen && a == 3'd5) m_ien = d[1:0];
        m_gpi1 = gv1(n-1);
        m_gpi2 = gv2(n-1);
        @(posedge Clk);
        #1;
        check("gpo1", gpo1, m_gpo1);
        check("gpo2", gpo2, m_gpo2);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wd = d;
        tick();
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd_chk(logic [2:0] a, string tag);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        check(tag, bus.rd, m_rd(a));
        bus.sel = 1'b0;
    endtask

    task automatic rd_const(logic [2:0] a, logic [31:0] exp, string tag);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        check(tag, bus.rd, exp);
        bus.sel = 1'b0;
    endtask

    initial begin
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
        m_reset();
        gpi1 = 32'd5; gpi2 = 32'd5;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_gpo1", gpo1, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        #2 Rst = 1'b1;

        for (int i = 0; i < 6; i++) tick();
        rd_const(3'd0, 32'd5, "warm_gpi1");
        rd_const(3'd1, 32'd5, "warm_gpi2");
        rd_const(3'd4, 32'd0, "warm_chg");
        check("warm_irq", {31'd0, irq}, 32'd0);

        wr(3'd3, 32'h78);
        check("st_gpo2", gpo2, 32'h78);
        check("st_gpo1", gpo1, 32'h0);
        rd_const(3'd3, 32'h78, "ld_gpo2");
        wr(3'd0, 32'hFFFF_FFFF);
        rd_const(3'd0, 32'd5, "ro_gpi1");

        wr(3'd5, 32'd1);
        gpi1 = 32'd6;
        tick();
        rd_const(3'd0, 32'd5, "gpi1_e1");
        tick();
        rd_const(3'd0, 32'd6, "gpi1_e2");
        tick();
        rd_const(3'd4, 32'd1, "chg_e3");
        check("irq_e3", {31'd0, irq}, 32'd0);
        tick();
        check("irq_e4", {31'd0, irq}, 32'd1);

        gpi2 = 32'd7;
        repeat (3) tick();
        rd_const(3'd4, 32'd3, "chg3");
        wr(3'd4, 32'd1);
        rd_const(3'd4, 32'd2, "w1c_chg");
        tick();
        check("w1c_irq_off", {31'd0, irq}, 32'd0);

        gpi1 = 32'd8;
        repeat (3) tick();
        wr(3'd5, 32'd3);
        tick();
        check("ien3_irq", {31'd0, irq}, 32'd1);
        wr(3'd4, 32'd1);
        tick();
        check("ien3_keep", {31'd0, irq}, 32'd1);

        gpi1 = 32'd9;
        tick();
        tick();
        wr(3'd4, 32'd1);
        rd_const(3'd4, 32'd3, "set_wins");
        rd_chk(3'd4, "set_wins_m");

        wr(3'd2, 32'hDEAD_BEEF);
        check("pre_rst_gpo1", gpo1, 32'hDEAD_BEEF);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 3'd2; bus.wd = 32'h1234;
        #2 Rst = 1'b0;
        #1;
        check("async_gpo1", gpo1, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        @(posedge Clk);
        #1;
        check("pend_gpo1", gpo1, 32'd0);
        bus.we = 1'b0; bus.addr = 3'd4;
        #1;
        check("async_chg", bus.rd, 32'd0);
        bus.sel = 1'b0;
        m_reset();
        gpi1 = '0; gpi2 = '0;
        #1 Rst = 1'b1;

        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0: gpi1 = $urandom;
                1: gpi2 = $urandom;
                2: gpi1 = gpi1 ^ (32'd1 << $urandom_range(0, 31));
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0)
                wr(3'($urandom_range(0, 7)), $urandom);
            else
                tick();
            rd_chk(3'($urandom_range(0, 7)), "rnd_rd");
            if ($urandom_range(0, 7) == 0) begin
                bus.addr = 3'($urandom_range(0, 7));
                #1;
                check("nosel_rd", bus.rd, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
